uart_rx: RTL and testbench

UART receiver: the receive side of the team's 8N1 serial link at 9600 baud from a 50 MHz clock. Samples the asynchronous `rx` line at 16x oversampling, validates the start bit and deframes 8 data bits, LSB first. Presents each byte with a one-cycle `data_valid` strobe and flags bad stop bits. Sits between the board RX pin and any byte consumer, mirroring the existing transmitter.

---
 rtl/uart_rx.sv | 111 +++++++++++
 tb/tb_uart_rx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, LSB first, one-cycle data_valid/frame_err strobes.
// Optional `UART_RX_MAJORITY_EN: 3-sample majority vote at every decision tick.
module uart_rx #(
  parameter int DIVISOR = 326
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  localparam logic [8:0] BAUD_MAX = 9'(DIVISOR - 1);

  state_t      state, state_nxt;
  logic        rx_meta, rx_s, rx_s_d;
  logic [8:0]  baud_counter;
  logic [3:0]  sample_counter;
  logic [2:0]  bit_counter;
  logic [7:0]  shift_reg;
  logic        tick, mid_start, mid_bit, start_edge, rx_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rx_s_d, rx_s, rx_meta} <= 3'b111;
    else        {rx_s_d, rx_s, rx_meta} <= {rx_s, rx_meta, rx};
  end

  assign start_edge = rx_s_d & ~rx_s;
  assign tick       = (baud_counter == BAUD_MAX);
  assign mid_start  = tick && (sample_counter == 4'd7);
  assign mid_bit    = tick && (sample_counter == 4'd15);

`ifdef UART_RX_MAJORITY_EN
  // Previous two tick samples; with the current rx_s they form the 3-sample vote window.
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    hist <= 2'b11;
    else if (tick) hist <= {hist[0], rx_s};
  end

  assign rx_bit = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign rx_bit = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start_edge) state_nxt = START_BIT;
      START_BIT: if (mid_start)  state_nxt = rx_bit ? IDLE : DATA_BITS;
      DATA_BITS: if (mid_bit && bit_counter == 3'd7) state_nxt = STOP_BIT;
      STOP_BIT:  if (mid_bit)    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state != IDLE);
  end

  // Baud counter runs freely in IDLE so it is only realigned by a real start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_counter   <= '0;
      sample_counter <= '0;
      bit_counter    <= '0;
      shift_reg      <= '0;
      data           <= '0;
      data_valid     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE && start_edge) begin
        baud_counter   <= '0;
        sample_counter <= '0;
        bit_counter    <= '0;
      end else begin
        baud_counter <= tick ? '0 : baud_counter + 9'd1;
        if (state == START_BIT && mid_start && !rx_bit) sample_counter <= '0;
        else if (tick)                                  sample_counter <= sample_counter + 4'd1;
      end

      if (state == DATA_BITS && mid_bit) begin
        shift_reg   <= {rx_bit, shift_reg[7:1]};
        bit_counter <= bit_counter + 3'd1;
      end

      if (state == STOP_BIT && mid_bit) begin
        if (rx_bit) begin
          data       <= shift_reg;
          data_valid <= 1'b1;
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: directed frames plus random frames, small DIVISOR for speed.
module tb_uart_rx;

  localparam int DIV = 8;
  localparam int BIT = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid, rx_busy, frame_err;

  always #5 clk = ~clk;

  uart_rx #(.DIVISOR(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .data(data), .data_valid(data_valid), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  typedef struct packed { logic err; logic [7:0] d; } exp_t;
  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Reference: each bit is sampled at its centre; a one-tick glitch on the centre
  // flips the bit unless the 3-sample majority outvotes it.
  task automatic send(input logic [7:0] b, input logic stop, input int glitch);
    logic [7:0] e;
    e = b;
`ifndef UART_RX_MAJORITY_EN
    if (glitch >= 0) e[glitch] = ~b[glitch];
`endif
    if (stop) begin
      q.push_back({1'b0, e});
      last_good = e;
    end else begin
      q.push_back({1'b1, last_good});
    end
    hold(1'b0, BIT / 2);
    chk("busy_start", rx_busy, 1);
    hold(1'b0, BIT / 2);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch) begin
        hold(b[i], BIT / 2 - DIV / 2);
        hold(~b[i], DIV);
        hold(b[i], BIT / 2 - DIV / 2);
      end else begin
        hold(b[i], BIT / 2);
        chk("busy_data", rx_busy, 1);
        hold(b[i], BIT / 2);
      end
    end
    hold(stop, BIT);
  endtask

  initial begin
    exp_t e;

    fork
      begin
        #5000000;
        $display("FAIL watchdog: run did not complete, tests=%0d", tests);
        $fatal(1, "watchdog");
      end
      forever begin
        @(negedge clk);
        if (data_valid || frame_err) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: data_valid=%0b frame_err=%0b data=%0h", data_valid, frame_err, data);
          end else begin
            e = q.pop_front();
            chk("strobe_frame_err", frame_err, e.err);
            chk("strobe_data_valid", data_valid, !e.err);
            chk("strobe_data", data, e.d);
            chk("busy_at_strobe", rx_busy, 0);
          end
        end
      end
    join_none

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", data_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", rx_busy, 0);
    rst_n = 1'b1;
    hold(1'b1, BIT);

    // good frame
    send(8'hA5, 1'b1, -1);
    hold(1'b1, BIT);
    chk("busy_idle", rx_busy, 0);

    // false start: low for 4 ticks
    rx = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    chk("false_busy_early", rx_busy, 1);
    repeat (2 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (4 * DIV - 4) @(negedge clk);
    chk("false_busy_pre", rx_busy, 1);
    repeat (10) @(negedge clk);
    chk("false_busy_post", rx_busy, 0);
    hold(1'b1, BIT);

    // framing error after a good byte
    send(8'h11, 1'b1, -1);
    hold(1'b1, BIT);
    send(8'h3C, 1'b0, -1);
    hold(1'b1, BIT);
    chk("data_hold", data, 8'h11);

    // back-to-back
    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    hold(1'b1, BIT);

    // reset during bit 4 of 0x5A
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(((8'h5A >> i) & 8'h01) != 0, BIT);
    hold(1'b1, BIT / 2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy", rx_busy, 0);
    chk("abort_data", data, 8'h00);
    rst_n = 1'b1;
    last_good = 8'h00;
    hold(1'b1, 2 * BIT);
    send(8'hC3, 1'b1, -1);
    hold(1'b1, BIT);

    // one-tick glitch on bit-3 decision
    send(8'h00, 1'b1, 3);
    hold(1'b1, BIT);

    // random frames
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      logic       st;
      int         g;
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      send(b, st, g);
      hold(1'b1, st ? int'($urandom_range(0, BIT)) : BIT + int'($urandom_range(0, BIT)));
    end

    repeat (20) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
